// File: rtl/e203_exu_pkg.sv
// Shared EXU definitions: default datapath widths, the write-back packet
// layout and the width of the ALU starvation counter.
package e203_exu_pkg;

  localparam int unsigned XLEN_DFLT    = 32;
  localparam int unsigned RFIDX_W_DFLT = 5;
  localparam int unsigned STARVE_CNT_W = 4;

  // One register-file write: data plus destination index.
  typedef struct packed {
    logic [XLEN_DFLT-1:0]    wdat;
    logic [RFIDX_W_DFLT-1:0] rdidx;
  } wbck_pkt_t;

endpackage

// File: rtl/e203_exu_wbck_hold.sv
// One-entry ALU hold buffer plus its starvation counter.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   load/load_*         : capture an ALU result that lost to long-pipe
//   drain               : buffered entry was granted this cycle
//   longp_win           : long-pipe was granted this cycle
//   buf_vld/buf_*       : buffered entry (registered)
//   starve_hit_c        : buffered entry has lost STARVE_MAX times in a row
module e203_exu_wbck_hold
  import e203_exu_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DFLT,
  parameter int unsigned RFIDX_W    = RFIDX_W_DFLT,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [XLEN-1:0]    load_wdat,
  input  logic [RFIDX_W-1:0] load_rdidx,
  input  logic               drain,
  input  logic               longp_win,
  output logic               buf_vld,
  output logic [XLEN-1:0]    buf_wdat,
  output logic [RFIDX_W-1:0] buf_rdidx,
  output logic               starve_hit_c
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] starve_cnt;

  assign starve_hit_c = buf_vld & (starve_cnt == CNT_MAX);

  // Buffer state and starvation counter; counter only runs while the
  // buffered entry keeps losing to long-pipe, and saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld    <= 1'b0;
      buf_wdat   <= '0;
      buf_rdidx  <= '0;
      starve_cnt <= '0;
    end else begin
      if (drain) begin
        buf_vld <= 1'b0;
      end else if (load) begin
        buf_vld <= 1'b1;
      end
      if (load) begin
        buf_wdat  <= load_wdat;
        buf_rdidx <= load_rdidx;
      end
      if (buf_vld & longp_win) begin
        if (starve_cnt != CNT_MAX) begin
          starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Write-back arbiter: merges ALU and long-pipe results onto the single
// register-file write port through a registered output stage.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   alu_wbck_i_*              : ALU result handshake and payload
//   longp_wbck_i_*            : long-pipe (LSU, mul/div) handshake and payload
//   rf_wbck_o_*               : registered register-file write port
//   wbck_busy                 : ALU hold buffer occupied
module e203_exu_wbck_arb
  import e203_exu_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DFLT,
  parameter int unsigned RFIDX_W    = RFIDX_W_DFLT,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
  output logic               rf_wbck_o_ena,
  output logic [XLEN-1:0]    rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
  output logic               wbck_busy
);

  logic               buf_vld;
  logic [XLEN-1:0]    buf_wdat;
  logic [RFIDX_W-1:0] buf_rdidx;
  logic               starve_hit_c;

  logic               alu_xfer_c;
  logic               longp_xfer_c;
  logic               grant_c;
  logic [XLEN-1:0]    gnt_wdat_c;
  logic [RFIDX_W-1:0] gnt_rdidx_c;
  logic               buf_load_c;
  logic               buf_drain_c;
  logic               longp_win_c;

  // Readies depend only on registered state, never on the valids.
  assign alu_wbck_i_ready   = ~buf_vld;
  assign longp_wbck_i_ready = ~starve_hit_c;
  assign wbck_busy          = buf_vld;

  assign alu_xfer_c   = alu_wbck_i_valid & alu_wbck_i_ready;
  assign longp_xfer_c = longp_wbck_i_valid & longp_wbck_i_ready;

  e203_exu_wbck_hold #(
    .XLEN      (XLEN),
    .RFIDX_W   (RFIDX_W),
    .STARVE_MAX(STARVE_MAX)
  ) u_hold (
    .clk         (clk),
    .rst         (rst),
    .load        (buf_load_c),
    .load_wdat   (alu_wbck_i_wdat),
    .load_rdidx  (alu_wbck_i_rdidx),
    .drain       (buf_drain_c),
    .longp_win   (longp_win_c),
    .buf_vld     (buf_vld),
    .buf_wdat    (buf_wdat),
    .buf_rdidx   (buf_rdidx),
    .starve_hit_c(starve_hit_c)
  );

  // Priority grant: starved buffer, long-pipe, buffer, direct ALU.
  // An ALU transfer can only happen with the buffer empty, so losing to
  // long-pipe simply parks it in the buffer.
  always_comb begin
    grant_c     = 1'b0;
    gnt_wdat_c  = '0;
    gnt_rdidx_c = '0;
    buf_load_c  = 1'b0;
    buf_drain_c = 1'b0;
    longp_win_c = 1'b0;
    if (starve_hit_c) begin
      grant_c     = 1'b1;
      gnt_wdat_c  = buf_wdat;
      gnt_rdidx_c = buf_rdidx;
      buf_drain_c = 1'b1;
    end else if (longp_xfer_c) begin
      grant_c     = 1'b1;
      gnt_wdat_c  = longp_wbck_i_wdat;
      gnt_rdidx_c = longp_wbck_i_rdidx;
      longp_win_c = 1'b1;
      buf_load_c  = alu_xfer_c;
    end else if (buf_vld) begin
      grant_c     = 1'b1;
      gnt_wdat_c  = buf_wdat;
      gnt_rdidx_c = buf_rdidx;
      buf_drain_c = 1'b1;
    end else if (alu_xfer_c) begin
      grant_c     = 1'b1;
      gnt_wdat_c  = alu_wbck_i_wdat;
      gnt_rdidx_c = alu_wbck_i_rdidx;
    end
  end

  // Registered write port; x0 writes are consumed with the enable low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wbck_o_ena   <= 1'b0;
      rf_wbck_o_wdat  <= '0;
      rf_wbck_o_rdidx <= '0;
    end else begin
      rf_wbck_o_ena <= grant_c & (|gnt_rdidx_c);
      if (grant_c) begin
        rf_wbck_o_wdat  <= gnt_wdat_c;
        rf_wbck_o_rdidx <= gnt_rdidx_c;
      end
    end
  end

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Randomized bench for the write-back arbiter with an in-bench reference
// model plus directed scenarios pinned by literal expectations.
module tb_e203_exu_wbck_arb;
  import e203_exu_pkg::*;

  localparam int unsigned XLEN    = XLEN_DFLT;
  localparam int unsigned RFIDX_W = RFIDX_W_DFLT;
  localparam int          SMAX    = 4;

  logic               clk;
  logic               rst;
  logic               alu_wbck_i_valid;
  logic               alu_wbck_i_ready;
  logic [XLEN-1:0]    alu_wbck_i_wdat;
  logic [RFIDX_W-1:0] alu_wbck_i_rdidx;
  logic               longp_wbck_i_valid;
  logic               longp_wbck_i_ready;
  logic [XLEN-1:0]    longp_wbck_i_wdat;
  logic [RFIDX_W-1:0] longp_wbck_i_rdidx;
  logic               rf_wbck_o_ena;
  logic [XLEN-1:0]    rf_wbck_o_wdat;
  logic [RFIDX_W-1:0] rf_wbck_o_rdidx;
  logic               wbck_busy;

  e203_exu_wbck_arb #(
    .XLEN      (XLEN),
    .RFIDX_W   (RFIDX_W),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .alu_wbck_i_valid  (alu_wbck_i_valid),
    .alu_wbck_i_ready  (alu_wbck_i_ready),
    .alu_wbck_i_wdat   (alu_wbck_i_wdat),
    .alu_wbck_i_rdidx  (alu_wbck_i_rdidx),
    .longp_wbck_i_valid(longp_wbck_i_valid),
    .longp_wbck_i_ready(longp_wbck_i_ready),
    .longp_wbck_i_wdat (longp_wbck_i_wdat),
    .longp_wbck_i_rdidx(longp_wbck_i_rdidx),
    .rf_wbck_o_ena     (rf_wbck_o_ena),
    .rf_wbck_o_wdat    (rf_wbck_o_wdat),
    .rf_wbck_o_rdidx   (rf_wbck_o_rdidx),
    .wbck_busy         (wbck_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Tiny register-file stand-in: flags any write that reaches x0.
  logic x0_bad = 1'b0;
  always @(posedge clk) begin
    if (rf_wbck_o_ena && rf_wbck_o_rdidx == '0) x0_bad <= 1'b1;
  end

  // Reference model state: pending buffered ALU result, how many times in a
  // row it has lost to long-pipe, and the expected write-port contents.
  bit        m_held;
  wbck_pkt_t m_held_pkt;
  int        m_losses;
  bit        e_ena;
  wbck_pkt_t e_out;

  function automatic wbck_pkt_t pk(input logic [XLEN-1:0] wd, input logic [RFIDX_W-1:0] rd);
    wbck_pkt_t p;
    p.wdat  = wd;
    p.rdidx = rd;
    return p;
  endfunction

  function automatic bit m_alu_rdy();
    return !m_held;
  endfunction

  function automatic bit m_lp_rdy();
    return !(m_held && m_losses >= SMAX);
  endfunction

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("ena", XLEN'(rf_wbck_o_ena), XLEN'(e_ena));
    chk("wdat", rf_wbck_o_wdat, e_out.wdat);
    chk("rdidx", XLEN'(rf_wbck_o_rdidx), XLEN'(e_out.rdidx));
    chk("busy", XLEN'(wbck_busy), XLEN'(m_held));
    chk("alu_ready", XLEN'(alu_wbck_i_ready), XLEN'(m_alu_rdy()));
    chk("longp_ready", XLEN'(longp_wbck_i_ready), XLEN'(m_lp_rdy()));
  endtask

  // One clock: drive inputs, advance the model by the arbitration rules,
  // then compare every output on the following falling edge.
  task automatic cycle(input bit r, input bit av, input wbck_pkt_t ap,
                       input bit lv, input wbck_pkt_t lp);
    bit        ax;
    bit        lx;
    bit        g;
    wbck_pkt_t gp;
    rst                = r;
    alu_wbck_i_valid   = av;
    alu_wbck_i_wdat    = ap.wdat;
    alu_wbck_i_rdidx   = ap.rdidx;
    longp_wbck_i_valid = lv;
    longp_wbck_i_wdat  = lp.wdat;
    longp_wbck_i_rdidx = lp.rdidx;
    ax = av && m_alu_rdy();
    lx = lv && m_lp_rdy();
    g  = 1'b0;
    gp = '0;
    if (r) begin
      m_held   = 1'b0;
      m_losses = 0;
      e_ena    = 1'b0;
      e_out    = '0;
    end else begin
      if (m_held && m_losses >= SMAX) begin
        g = 1'b1; gp = m_held_pkt; m_held = 1'b0; m_losses = 0;
      end else if (lx) begin
        g = 1'b1; gp = lp;
        if (m_held) m_losses = (m_losses + 1 > SMAX) ? SMAX : m_losses + 1;
        else        m_losses = 0;
        if (ax) begin
          m_held = 1'b1; m_held_pkt = ap;
        end
      end else if (m_held) begin
        g = 1'b1; gp = m_held_pkt; m_held = 1'b0; m_losses = 0;
      end else if (ax) begin
        g = 1'b1; gp = ap;
      end
      e_ena = g && (gp.rdidx != '0);
      if (g) e_out = gp;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    wbck_pkt_t z;
    z = '0;
    m_held = 1'b0; m_held_pkt = '0; m_losses = 0; e_ena = 1'b0; e_out = '0;

    // Reset state
    cycle(1'b1, 1'b0, z, 1'b0, z);
    cycle(1'b1, 1'b0, z, 1'b0, z);
    chk("rst_ena", XLEN'(rf_wbck_o_ena), 0);
    chk("rst_alu_rdy", XLEN'(alu_wbck_i_ready), 1);
    chk("rst_lp_rdy", XLEN'(longp_wbck_i_ready), 1);
    chk("rst_busy", XLEN'(wbck_busy), 0);

    // Single ALU write
    cycle(1'b0, 1'b1, pk(32'hDEADBEEF, 5'd5), 1'b0, z);
    chk("single_ena", XLEN'(rf_wbck_o_ena), 1);
    chk("single_rd", XLEN'(rf_wbck_o_rdidx), 5);
    chk("single_wd", rf_wbck_o_wdat, 32'hDEADBEEF);
    idle();
    chk("single_ena_off", XLEN'(rf_wbck_o_ena), 0);

    // Collision: long-pipe first, ALU next cycle
    cycle(1'b0, 1'b1, pk(32'h11, 5'd3), 1'b1, pk(32'h22, 5'd7));
    chk("coll1_rd", XLEN'(rf_wbck_o_rdidx), 7);
    chk("coll1_wd", rf_wbck_o_wdat, 32'h22);
    chk("coll1_busy", XLEN'(wbck_busy), 1);
    idle();
    chk("coll2_rd", XLEN'(rf_wbck_o_rdidx), 3);
    chk("coll2_wd", rf_wbck_o_wdat, 32'h11);
    chk("coll2_ena", XLEN'(rf_wbck_o_ena), 1);
    chk("coll2_busy", XLEN'(wbck_busy), 0);

    // Starvation: rd=9 buffered while long-pipe streams
    cycle(1'b0, 1'b1, pk(32'h99, 5'd9), 1'b1, pk(32'h21, 5'd1));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, z, 1'b1, pk(32'h100 + XLEN'(i), RFIDX_W'(10 + i)));
    chk("starve_lp_rdy", XLEN'(longp_wbck_i_ready), 0);
    chk("starve_busy", XLEN'(wbck_busy), 1);
    cycle(1'b0, 1'b0, z, 1'b1, pk(32'h77, 5'd20));
    chk("starve_rd", XLEN'(rf_wbck_o_rdidx), 9);
    chk("starve_wd", rf_wbck_o_wdat, 32'h99);
    chk("starve_lp_back", XLEN'(longp_wbck_i_ready), 1);
    cycle(1'b0, 1'b0, z, 1'b1, pk(32'h77, 5'd20));
    chk("starve_resume", XLEN'(rf_wbck_o_rdidx), 20);

    // x0 drop
    chk("x0_lp_rdy", XLEN'(longp_wbck_i_ready), 1);
    cycle(1'b0, 1'b0, z, 1'b1, pk(32'h55, 5'd0));
    chk("x0_ena", XLEN'(rf_wbck_o_ena), 0);
    chk("x0_wd", rf_wbck_o_wdat, 32'h55);
    idle();
    chk("x0_reads_zero", XLEN'(x0_bad), 0);

    // Back-pressure: held ALU valid waits for the buffer to drain
    cycle(1'b0, 1'b1, pk(32'h44, 5'd4), 1'b1, pk(32'h88, 5'd8));
    chk("bp_rd0", XLEN'(rf_wbck_o_rdidx), 8);
    chk("bp_alu_rdy0", XLEN'(alu_wbck_i_ready), 0);
    cycle(1'b0, 1'b1, pk(32'h66, 5'd6), 1'b0, z);
    chk("bp_rd1", XLEN'(rf_wbck_o_rdidx), 4);
    chk("bp_wd1", rf_wbck_o_wdat, 32'h44);
    chk("bp_alu_rdy1", XLEN'(alu_wbck_i_ready), 1);
    cycle(1'b0, 1'b1, pk(32'h66, 5'd6), 1'b0, z);
    chk("bp_rd2", XLEN'(rf_wbck_o_rdidx), 6);
    chk("bp_wd2", rf_wbck_o_wdat, 32'h66);
    idle();
    chk("bp_once", XLEN'(rf_wbck_o_ena), 0);

    // Reset mid-operation drops the buffered result
    cycle(1'b0, 1'b1, pk(32'hAB, 5'd11), 1'b1, pk(32'hCD, 5'd12));
    chk("mrst_busy0", XLEN'(wbck_busy), 1);
    cycle(1'b1, 1'b0, z, 1'b0, z);
    chk("mrst_ena", XLEN'(rf_wbck_o_ena), 0);
    chk("mrst_busy", XLEN'(wbck_busy), 0);
    chk("mrst_alu_rdy", XLEN'(alu_wbck_i_ready), 1);
    chk("mrst_lp_rdy", XLEN'(longp_wbck_i_ready), 1);
    idle();
    chk("mrst_no_write", XLEN'(rf_wbck_o_ena), 0);

    // Randomized traffic with occasional resets and x0 destinations
    for (int n = 0; n < 3000; n++) begin
      bit r;
      bit av;
      bit lv;
      r  = ($urandom_range(199) == 0);
      av = ($urandom_range(99) < 55);
      lv = ($urandom_range(99) < ((n / 500) % 2 == 1 ? 90 : 45));
      cycle(r, av, pk(XLEN'($urandom), RFIDX_W'($urandom_range(31))),
               lv, pk(XLEN'($urandom), RFIDX_W'($urandom_range(31))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e203_exu_wbck_arb.md
# e203_exu_wbck_arb

Write-back arbiter in the EXU that sits directly upstream of the general-purpose register file and drives its single write port. It merges results from the single-cycle ALU path and the long-pipe path (LSU and multiply/divide). A one-entry ALU hold buffer and a starvation counter guarantee forward progress for both sources. All outputs are registered, so the register file sees a clean, glitch-free write port.

## Interface
Parameters:
- XLEN, 32: data width.
- RFIDX_W, 5: register index width.
- STARVE_MAX, 4: number of consecutive cycles a buffered ALU result may lose to long-pipe before it is forced through. Legal range is 1..15.

Ports:
- clk, in, 1: single clock. All state updates on the rising edge.
- rst, in, 1: reset, synchronous and active-high.
- alu_wbck_i_valid, in, 1: ALU result valid.
- alu_wbck_i_ready, out, 1: ALU result accepted.
- alu_wbck_i_wdat, in, XLEN: ALU result data.
- alu_wbck_i_rdidx, in, RFIDX_W: ALU destination register.
- longp_wbck_i_valid, in, 1: long-pipe result valid.
- longp_wbck_i_ready, out, 1: long-pipe result accepted.
- longp_wbck_i_wdat, in, XLEN: long-pipe result data.
- longp_wbck_i_rdidx, in, RFIDX_W: long-pipe destination register.
- rf_wbck_o_ena, out, 1: register-file write enable (registered).
- rf_wbck_o_wdat, out, XLEN: register-file write data (registered).
- rf_wbck_o_rdidx, out, RFIDX_W: register-file write index (registered).
- wbck_busy, out, 1: the ALU hold buffer is occupied.

## Operation
- A transfer on a source occurs when valid & ready are both high in the same cycle.
- State:
  - alu_buf_vld, plus alu_buf_wdat and alu_buf_rdidx.
  - starve_cnt, a 4-bit counter.
  - The output register.
- Both ready signals are independent of both valid inputs:
  - alu_wbck_i_ready = ~alu_buf_vld.
  - longp_wbck_i_ready = ~(alu_buf_vld & (starve_cnt == STARVE_MAX)).
- Grant selection, first match wins, at most one grant per cycle:
  1. Forced: alu_buf_vld & starve_cnt == STARVE_MAX. The buffer is granted and long-pipe stalls.
  2. Long-pipe transfer: long-pipe is granted. A buffered entry stays in the buffer. A new ALU transfer in the same cycle is written into the buffer.
  3. alu_buf_vld: the buffer is granted and the buffer clears.
  4. ALU transfer with the buffer empty: the ALU input is granted directly.
  5. No grant.
- ALU results are written in acceptance order. The buffer always drains before a new ALU transfer can be accepted.
- starve_cnt:
  - Increments when the buffer is valid and long-pipe is granted.
  - Clears to 0 when the buffer is granted or is empty.
  - Saturates at STARVE_MAX.
- Output register, loaded each cycle:
  - rf_wbck_o_ena = grant & (granted rdidx != 0).
  - wdat and rdidx take the granted values whenever there is a grant; otherwise they hold.
  - Writes to x0 are accepted and consumed, but the enable stays low.
- WAW ordering between the two sources is not checked here. Dispatch guarantees that no two in-flight results target the same register.

## Timing
- Latency: a source transfer in cycle N produces rf_wbck_o_ena in cycle N+1. The register file captures the value at the end of N+1, and it is readable in N+2.
- A buffered ALU result is written no later than STARVE_MAX+1 cycles after it is buffered. Throughput is one write per cycle.
- Reset values:
  - rf_wbck_o_ena = 0, rf_wbck_o_wdat = 0, rf_wbck_o_rdidx = 0.
  - alu_buf_vld = 0, starve_cnt = 0, wbck_busy = 0.
  - alu_wbck_i_ready = 1, longp_wbck_i_ready = 1.
- Reset asserted mid-operation: a buffered or pending result is discarded, and no write issues in the cycle after reset.
- Both sources valid with the buffer empty: long-pipe is written in N+1, and the ALU result is buffered and written in N+2 unless long-pipe continues streaming.

## Structure
- Shared package e203_exu_pkg holds:
  - XLEN and RFIDX_W defaults.
  - A wbck_pkt_t typedef {wdat, rdidx}.
  - The STARVE_CNT_W = 4 constant.
- One sub-module, e203_exu_wbck_hold: the one-entry ALU hold buffer with its valid flag and the starvation counter. The top level holds the grant mux and the output register.

## Test plan
- Single ALU write: ALU valid with rd=5, data=0xDEADBEEF and longp idle → in N+1, ena=1, rdidx=5, wdat=0xDEADBEEF; in N+2, ena=0.
- Collision: in cycle N, ALU rd=3/0x11 and longp rd=7/0x22 → N+1 writes 7/0x22; N+2 writes 3/0x11; wbck_busy is high during N+1 only.
- Starvation: buffer holds rd=9 while longp streams continuously → after 4 longp writes, longp_ready=0 for one cycle, then rd=9 is written and longp resumes the next cycle.
- x0 drop: longp rd=0, data=0x55 → ready=1 and the transfer is consumed; ena stays 0, and the regfile x0 still reads 0.
- Back-pressure: the buffer is full and a new ALU valid is held → alu_ready=0 until the buffer drains; the held result is written exactly once, in order.
- Reset mid-operation: the buffer is full and rst is pulsed → the next cycle shows ena=0, busy=0, both readies=1, and the buffered data is never written.
